// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the ping-pong game blocks.
//   game_state_e : game-flow FSM states (IDLE, PLAY, HOLD, GAME_OVER)
//   LIVES_MAX    : largest lives count the 2-bit life value can show
//   HOLD_CNT_W   : width of the frame counter used for the serve pause
// ---------------------------------------------------------------------------
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        HOLD      = 2'd2,
        GAME_OVER = 2'd3
    } game_state_e;

    localparam int LIVES_MAX  = 3;
    localparam int HOLD_CNT_W = 8;

endpackage

// File: rtl/btn_sync_edge.sv
// ---------------------------------------------------------------------------
// btn_sync_edge
// Brings a raw asynchronous push button into the clk domain and turns each
// press into a single-cycle pulse. Holding the button gives only one pulse.
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-high reset
//   btn_in   : raw asynchronous button level, active-high
//   btn_edge : registered one-cycle pulse on each synchronised rising edge
// A rise sampled at edge N shows on btn_edge after edge N+2, so a consumer
// registering on btn_edge reacts at edge N+3.
// ---------------------------------------------------------------------------
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_edge
);

    logic sync1_q;
    logic sync2_q;
    logic sync3_q;
    logic edge_q;

    // Two synchroniser flops, a delayed copy for edge detection, and a
    // registered pulse so that the consumer sees a clean flop output.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= sync2_q & ~sync3_q;
        end
    end

    assign btn_edge = edge_q;

endmodule

// File: rtl/life_tracker.sv
// ---------------------------------------------------------------------------
// life_tracker
// Game-flow FSM owning the remaining-lives count for the ping-pong game.
// Parameters:
//   LIVES_INIT  : lives loaded at reset and on restart (1..3)
//   HOLD_FRAMES : frame ticks paused after a miss or restart (1..255)
// Ports:
//   clk        : pixel/system clock
//   reset      : synchronous, active-high reset
//   start_btn  : raw asynchronous start button, active-high
//   miss       : level, high while the ball is past the paddle edge
//   frame_tick : one-cycle pulse per video frame
//   life       : remaining lives, 0..3 (registered)
//   play_en    : ball/paddle motion enable (registered)
//   ball_reset : hold ball at centre while high (registered)
//   game_over  : high while in GAME_OVER (registered)
// ---------------------------------------------------------------------------
module life_tracker
    import pong_pkg::*;
#(
    parameter int LIVES_INIT  = 3,
    parameter int HOLD_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       miss,
    input  logic       frame_tick,
    output logic [1:0] life,
    output logic       play_en,
    output logic       ball_reset,
    output logic       game_over
);

    localparam logic [1:0]            LIVES_RST = 2'(LIVES_INIT);
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_FRAMES - 1);

    game_state_e           state_q, state_d;
    logic [1:0]            life_q, life_d;
    logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;
    logic                  play_en_q, play_en_d;
    logic                  ball_reset_q, ball_reset_d;
    logic                  game_over_q, game_over_d;
    logic                  start_edge;

    btn_sync_edge u_start_sync (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (start_btn),
        .btn_edge (start_edge)
    );

    // State, lives, hold counter and all outputs are flops; the outputs are
    // decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            life_q       <= LIVES_RST;
            cnt_q        <= '0;
            play_en_q    <= 1'b0;
            ball_reset_q <= 1'b1;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            life_q       <= life_d;
            cnt_q        <= cnt_d;
            play_en_q    <= play_en_d;
            ball_reset_q <= ball_reset_d;
            game_over_q  <= game_over_d;
        end
    end

    // Next-state logic. HOLD ignores miss, which is what makes a long miss
    // cost only one life. The counter is cleared on HOLD entry, so a tick
    // arriving in the entry cycle is seen by PLAY/GAME_OVER and not counted.
    // Life is only decremented from 2 or more; the last life loads 0
    // directly, so the 2-bit count can never wrap.
    always_comb begin
        state_d = state_q;
        life_d  = life_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (miss) begin
                    if (life_q > 2'd1) begin
                        life_d  = life_q - 2'd1;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        life_d  = 2'd0;
                        state_d = GAME_OVER;
                    end
                end
            end
            HOLD: begin
                if (frame_tick) begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        state_d = PLAY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            GAME_OVER: begin
                if (start_edge) begin
                    life_d  = LIVES_RST;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        play_en_d    = (state_d == PLAY);
        ball_reset_d = (state_d != PLAY);
        game_over_d  = (state_d == GAME_OVER);
    end

    assign life       = life_q;
    assign play_en    = play_en_q;
    assign ball_reset = ball_reset_q;
    assign game_over  = game_over_q;

endmodule

// File: doc/life_tracker.md
Name: life_tracker

Overview:
- Game-flow FSM that owns the remaining-lives count for the ping-pong game.
- Drives the 2-bit `life` value consumed by the on-screen lives-digit renderer, the ball-motion enable, and the ball-recentre request.
- Detects each ball miss exactly once and inserts a frame-counted pause before the next serve.
- Handles start, game-over and restart from a synchronised push button.

Parameters:
- LIVES_INIT, 3, lives loaded at reset and on restart; legal range 1..3.
- HOLD_FRAMES, 60, frame ticks spent paused after a miss or restart before auto-serve; legal range 1..255.

Ports:
- clk  in  1  pixel/system clock
- reset  in  1  synchronous, active-high reset
- start_btn  in  1  raw asynchronous push button, active-high
- miss  in  1  level; high while the ball is past the player's paddle edge
- frame_tick  in  1  one-cycle pulse, once per video frame
- life  out  2  remaining lives, 0..3
- play_en  out  1  ball/paddle motion enable
- ball_reset  out  1  hold ball at centre while high
- game_over  out  1  high while in GAME_OVER

Behaviour:
- Clock and reset (already decided): one clock, `clk`. Reset is synchronous and active-high, named `reset`.
- All outputs are registered.
- Reset values: life=LIVES_INIT, play_en=0, ball_reset=1, game_over=0, state=IDLE, hold counter=0, synchroniser flops=0.
- Start path:
  - start_btn passes through a 2-flop synchroniser plus one edge register.
  - start_edge = sync2 & ~sync3, a one-cycle pulse.
  - A button rising before clock edge N produces its state/output change at edge N+3.
  - Holding the button produces no further edges.
- IDLE:
  - Outputs: play_en=0, ball_reset=1.
  - start_edge -> PLAY.
- PLAY:
  - Outputs: play_en=1, ball_reset=0.
  - miss=1 and life>1 -> life<=life-1, clear counter, go to HOLD.
  - miss=1 and life==1 -> life<=0, go to GAME_OVER.
  - start_edge in PLAY is ignored; miss has priority when both occur in the same cycle.
- HOLD:
  - Outputs: play_en=0, ball_reset=1.
  - Counter increments on each frame_tick.
  - When the counter reaches HOLD_FRAMES-1 and frame_tick=1 -> PLAY, counter<=0.
  - miss and start_edge are ignored.
  - A frame_tick in the same cycle as HOLD entry is not counted, because the counter clears on entry.
- GAME_OVER:
  - Outputs: play_en=0, ball_reset=1, game_over=1, life=0.
  - start_edge -> life<=LIVES_INIT, clear counter, go to HOLD.
  - game_over falls on the same edge.
- Miss counting: each miss costs exactly one life even if `miss` stays high for many cycles.
  - This is guaranteed because HOLD ignores miss.
  - If miss is still high when HOLD exits to PLAY, it counts as a new miss on the next cycle. This is the intended behaviour; upstream drops miss once ball_reset recentres the ball.
- Width rules:
  - life never underflows or wraps. The decrement is only taken when life>=2; the life==1 case loads 0.
  - Hold counter is 8 bits.
- Reset asserted in any state, including mid-HOLD, returns to IDLE with reset values on the next edge.

Decomposition:
- Shared package `pong_pkg`:
  - state enum (IDLE=2'd0, PLAY=2'd1, HOLD=2'd2, GAME_OVER=2'd3);
  - LIVES_MAX=3;
  - HOLD_CNT_W=8.
- One sub-module, `btn_sync_edge`: 2-flop synchroniser plus rising-edge pulse.
  - Ports: clk, reset, btn_in, btn_edge.
  - Also reused by the paddle-control block.

Test Plan:
1. Reset, then start_btn high for 5 cycles -> play_en rises exactly 3 cycles after the first sampled high. life=3, ball_reset=0. Only one edge is produced.
2. In PLAY, miss held high for 200 cycles -> life goes 3->2 once. play_en=0 and ball_reset=1 for exactly HOLD_FRAMES frame_ticks, then PLAY with life=2.
3. Three separate misses, each pulsed 10 cycles and after each HOLD completes -> life goes 3,2,1,0. game_over=1 on the third miss and HOLD is not entered.
4. In GAME_OVER, pulse start -> life=3, game_over=0, HOLD for 60 ticks, then play_en=1.
5. miss and start_edge in the same PLAY cycle -> life decrements and HOLD is entered; start has no effect. frame_tick coincident with HOLD entry is not counted, so the exit comes on the 60th subsequent tick.
6. reset asserted at tick 30 of HOLD with life=1 -> next edge: IDLE, life=3, play_en=0, ball_reset=1, game_over=0.
